// File: rtl/uart_rx_fifo_pkg.sv
// Shared defaults for the UART receive FIFO slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_rx_fifo_pkg;

    localparam int DEF_DATA_LEN = 8;   // one UART byte per entry
    localparam int DEF_ADDR_LEN = 4;   // 16-entry default depth

endpackage

// File: rtl/fifo_ram.sv
// Register-array storage for the UART receive FIFO.
// Latency: write lands at the rising edge; read is combinational from the address.
// Backpressure: none; the caller qualifies the write enable.
//
// Ports:
//   i_clk    - system clock
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address
//   o_rdata  - data stored at i_raddr
module fifo_ram
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_LEN = DEF_DATA_LEN,
    parameter int ADDR_LEN = DEF_ADDR_LEN
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [ADDR_LEN-1:0] i_waddr,
    input  logic [DATA_LEN-1:0] i_wdata,
    input  logic [ADDR_LEN-1:0] i_raddr,
    output logic [DATA_LEN-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_LEN;

    // Contents are deliberately not reset; the pointers define validity.
    logic [DATA_LEN-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO between the UART receiver and the debug word assembler.
// Latency: a byte pushed at edge N is on o_rd_data in the next cycle; no read latency.
// Backpressure: none; pushes while full are dropped and flagged, pops while empty are flagged.
//
// Ports:
//   i_clk, i_reset        - clock and synchronous active-high reset
//   i_wr, i_wr_data       - push strobe and byte
//   i_rd                  - pop strobe (consumer samples o_rd_data first)
//   o_rd_data             - head entry, valid while o_empty=0
//   o_empty, o_full       - occupancy flags
//   o_count               - occupancy, 0 .. 2**ADDR_LEN
//   i_clear_err           - clears the sticky error flags
//   o_overflow            - sticky: push attempted while full
//   o_underflow           - sticky: pop attempted while empty
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_LEN = DEF_DATA_LEN,
    parameter int ADDR_LEN = DEF_ADDR_LEN
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_wr,
    input  logic [DATA_LEN-1:0] i_wr_data,
    input  logic                i_rd,
    output logic [DATA_LEN-1:0] o_rd_data,
    output logic                o_empty,
    output logic                o_full,
    output logic [ADDR_LEN:0]   o_count,
    input  logic                i_clear_err,
    output logic                o_overflow,
    output logic                o_underflow
);

    localparam logic [ADDR_LEN:0] PTR_ONE = {{ADDR_LEN{1'b0}}, 1'b1};

    // One extra pointer bit distinguishes full from empty when the low bits match.
    logic [ADDR_LEN:0] r_wr_ptr;
    logic [ADDR_LEN:0] r_rd_ptr;
    logic              r_overflow;
    logic              r_underflow;

    logic w_empty;
    logic w_full;
    logic w_do_wr;
    logic w_do_rd;
    logic w_ovf_evt;
    logic w_udf_evt;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_LEN-1:0] == r_rd_ptr[ADDR_LEN-1:0]) &&
                     (r_wr_ptr[ADDR_LEN] != r_rd_ptr[ADDR_LEN]);

    // A pop is legal whenever data is present. When full, a same-cycle pop
    // frees the head slot, which is exactly the slot the push writes; the
    // head byte has already been consumed combinationally this cycle.
    assign w_do_rd   = i_rd && !w_empty;
    assign w_do_wr   = i_wr && (!w_full || i_rd);
    assign w_ovf_evt = i_wr && w_full && !i_rd;
    assign w_udf_evt = i_rd && w_empty;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            // A new error event in the clearing cycle keeps the flag set.
            r_overflow  <= (r_overflow  && !i_clear_err) || w_ovf_evt;
            r_underflow <= (r_underflow && !i_clear_err) || w_udf_evt;
        end
    end

    fifo_ram #(
        .DATA_LEN (DATA_LEN),
        .ADDR_LEN (ADDR_LEN)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_do_wr && !i_reset),
        .i_waddr (r_wr_ptr[ADDR_LEN-1:0]),
        .i_wdata (i_wr_data),
        .i_raddr (r_rd_ptr[ADDR_LEN-1:0]),
        .o_rdata (o_rd_data)
    );

    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_count     = r_wr_ptr - r_rd_ptr;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, corner-case sequences,
// and randomized traffic against a queue-based reference model.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_uart_rx_fifo;

    localparam int DL    = 8;
    localparam int AL    = 4;
    localparam int DEPTH = 16;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_wr = 1'b0;
    logic [DL-1:0] i_wr_data = '0;
    logic          i_rd = 1'b0;
    logic          i_clear_err = 1'b0;
    logic [DL-1:0] o_rd_data;
    logic          o_empty;
    logic          o_full;
    logic [AL:0]   o_count;
    logic          o_overflow;
    logic          o_underflow;

    always #5 i_clk = ~i_clk;

    uart_rx_fifo #(.DATA_LEN(DL), .ADDR_LEN(AL)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_wr        (i_wr),
        .i_wr_data   (i_wr_data),
        .i_rd        (i_rd),
        .o_rd_data   (o_rd_data),
        .o_empty     (o_empty),
        .o_full      (o_full),
        .o_count     (o_count),
        .i_clear_err (i_clear_err),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: contents as a queue, flags as bits.
    logic [7:0] q[$];
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit wr, input logic [7:0] d, input bit rd,
                              input bit clr, input bit rst);
        bit was_full, was_empty;
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            m_ovf = (m_ovf && !clr) || (wr && was_full && !rd);
            m_udf = (m_udf && !clr) || (rd && was_empty);
            if (rd && !was_empty) void'(q.pop_front());
            if (wr && q.size() < DEPTH) q.push_back(d);
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, release strobes.
    task automatic apply(input bit wr, input logic [7:0] d, input bit rd,
                         input bit clr, input bit rst);
        i_wr = wr; i_wr_data = d; i_rd = rd; i_clear_err = clr; i_reset = rst;
        @(posedge i_clk);
        #1;
        model_step(wr, d, rd, clr, rst);
        i_wr = 1'b0; i_rd = 1'b0; i_clear_err = 1'b0; i_reset = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"}, 32'(o_count), 32'(q.size()));
        chk({tag, ".empty"}, 32'(o_empty), 32'(q.size() == 0));
        chk({tag, ".full"},  32'(o_full),  32'(q.size() == DEPTH));
        chk({tag, ".ovf"},   32'(o_overflow),  32'(m_ovf));
        chk({tag, ".udf"},   32'(o_underflow), 32'(m_udf));
        if (q.size() != 0) chk({tag, ".data"}, 32'(o_rd_data), 32'(q[0]));
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] d;
        bit         rd;
        bit         clr;
        bit         rst;
        bit         e_empty;
        bit         e_full;
        int         e_count;
        bit         e_ovf;
        bit         e_udf;
        logic [7:0] e_data;
    } vec_t;

    vec_t vt[$];

    initial begin
        logic [7:0] samp;
        logic [31:0] word;

        // wr d rd clr rst | empty full count ovf udf data
        vt.push_back('{0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 0, 8'h00}); // reset state
        vt.push_back('{1, 8'hA5, 0, 0, 0, 0, 0, 1, 0, 0, 8'hA5}); // push A5, visible next cycle
        vt.push_back('{0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00}); // pop -> empty
        vt.push_back('{0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 1, 8'h00}); // pop while empty
        vt.push_back('{0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 0, 8'h00}); // clear error
        vt.push_back('{1, 8'h12, 0, 0, 0, 0, 0, 1, 0, 0, 8'h12});
        vt.push_back('{1, 8'h34, 0, 0, 0, 0, 0, 2, 0, 0, 8'h12});
        vt.push_back('{1, 8'h56, 1, 0, 0, 0, 0, 2, 0, 0, 8'h34}); // push+pop mid-fill
        vt.push_back('{0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0, 8'h56});
        vt.push_back('{0, 8'h00, 1, 1, 0, 1, 0, 0, 0, 0, 8'h00});
        vt.push_back('{0, 8'h00, 1, 1, 0, 1, 0, 0, 0, 1, 8'h00}); // set wins over clear

        for (int i = 0; i < vt.size(); i++) begin
            apply(vt[i].wr, vt[i].d, vt[i].rd, vt[i].clr, vt[i].rst);
            chk($sformatf("vec%0d.empty", i), 32'(o_empty), 32'(vt[i].e_empty));
            chk($sformatf("vec%0d.full", i),  32'(o_full),  32'(vt[i].e_full));
            chk($sformatf("vec%0d.count", i), 32'(o_count), 32'(vt[i].e_count));
            chk($sformatf("vec%0d.ovf", i),   32'(o_overflow),  32'(vt[i].e_ovf));
            chk($sformatf("vec%0d.udf", i),   32'(o_underflow), 32'(vt[i].e_udf));
            if (!vt[i].e_empty) chk($sformatf("vec%0d.data", i), 32'(o_rd_data), 32'(vt[i].e_data));
        end

        // Fill to 16, overflow, drain in order.
        apply(0, 8'h00, 0, 1, 1);
        for (int i = 0; i < DEPTH; i++) apply(1, 8'(i), 0, 0, 0);
        chk("fill.full", 32'(o_full), 32'd1);
        chk("fill.count", 32'(o_count), 32'd16);
        apply(1, 8'hFF, 0, 0, 0);
        chk("ovf.flag", 32'(o_overflow), 32'd1);
        chk("ovf.count", 32'(o_count), 32'd16);
        chk("ovf.head", 32'(o_rd_data), 32'h00);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain%0d", i), 32'(o_rd_data), 32'(i));
            apply(0, 8'h00, 1, 0, 0);
        end
        chk("drain.empty", 32'(o_empty), 32'd1);
        chk("drain.ovf_sticky", 32'(o_overflow), 32'd1);
        apply(0, 8'h00, 0, 1, 0);
        check_model("clr1");

        // Full FIFO, simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) apply(1, 8'(8'h80 + i), 0, 0, 0);
        apply(1, 8'h55, 1, 0, 0);
        chk("fullrw.count", 32'(o_count), 32'd16);
        chk("fullrw.ovf", 32'(o_overflow), 32'd0);
        chk("fullrw.full", 32'(o_full), 32'd1);
        chk("fullrw.head", 32'(o_rd_data), 32'h81);
        samp = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            samp = o_rd_data;
            apply(0, 8'h00, 1, 0, 0);
        end
        chk("fullrw.last", 32'(samp), 32'h55);
        check_model("fullrw.end");

        // Empty FIFO, simultaneous push and pop.
        apply(1, 8'h3C, 1, 0, 0);
        chk("emptyrw.count", 32'(o_count), 32'd1);
        chk("emptyrw.data", 32'(o_rd_data), 32'h3C);
        chk("emptyrw.udf", 32'(o_underflow), 32'd1);
        apply(0, 8'h00, 0, 1, 0);
        chk("emptyrw.clr_udf", 32'(o_underflow), 32'd0);
        chk("emptyrw.clr_ovf", 32'(o_overflow), 32'd0);
        apply(0, 8'h00, 1, 0, 0);
        check_model("emptyrw.end");

        // Wrap-around traffic with occupancy kept within 1..15.
        for (int i = 0; i < 8; i++) apply(1, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 200; i++) begin
            bit wr, rd;
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            if (q.size() <= 1) rd = 1'b0;
            if (q.size() >= 15) wr = 1'b0;
            apply(wr, 8'($urandom), rd, 1'($urandom_range(0, 7) == 0), 0);
            check_model($sformatf("wrap%0d", i));
            chk($sformatf("wrap%0d.le16", i), 32'(o_count <= 5'd16), 32'd1);
        end

        // Unconstrained traffic: alternating fill/drain bias, occasional reset.
        for (int i = 0; i < 400; i++) begin
            int pw;
            pw = ((i / 40) % 2 == 0) ? 80 : 20;
            apply(32'($urandom_range(0, 99)) < pw, 8'($urandom),
                  32'($urandom_range(0, 99)) >= pw,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
            check_model($sformatf("rnd%0d", i));
        end

        // Word assembler reading four bytes, then reset mid-stream.
        apply(0, 8'h00, 0, 1, 1);
        apply(1, 8'h11, 0, 0, 0);
        apply(1, 8'h22, 0, 0, 0);
        apply(1, 8'h33, 0, 0, 0);
        apply(1, 8'h44, 0, 0, 0);
        word = 32'h0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("asm%0d.nonempty", k), 32'(o_empty), 32'd0);
            word = word | (32'(o_rd_data) << (8 * k));
            apply(0, 8'h00, 1, 0, 0);
        end
        chk("asm.word", word, 32'h44332211);
        apply(1, 8'h66, 0, 0, 0);
        apply(1, 8'h77, 0, 0, 0);
        apply(1, 8'h88, 1, 0, 1);
        chk("rst.empty", 32'(o_empty), 32'd1);
        chk("rst.count", 32'(o_count), 32'd0);
        check_model("rst.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
